bank_reader: RTL and testbench
==============================

BANK_READER -- requirements
Module: bank_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 8, is the width of one bank element in bits.
REQ-002 Parameter BANK_DEPTH, default 8, is the number of elements per bank.
REQ-003 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-004 reset  input  1  is the asynchronous, active-high reset.
REQ-005 start  input  1  is the read-burst request, sampled only in IDLE.
REQ-006 abort  input  1  is the synchronous burst cancel.
REQ-007 length  input  4  is the element count for the burst.
REQ-008 bank_data  input  DATA_WIDTH*BANK_DEPTH  is the parallel bank contents; element i sits at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 out_ready  input  1  is the downstream ready.
REQ-010 out_data  output  DATA_WIDTH  is the current element.
REQ-011 out_valid  output  1  is high when out_data holds a valid element.
REQ-012 out_last  output  1  marks the final element of the burst.
REQ-013 select_line  output  BANK_DEPTH  is the one-hot index of the element on out_data.
REQ-014 busy  output  1  is high in any state other than IDLE.
REQ-015 done  output  1  is a one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have three states: IDLE, STREAM and DONE.
REQ-017 IDLE with start=1: on the next edge, snapshot bank_data into an internal shadow bank, latch the effective length, clear index to 0 and enter STREAM.
REQ-018 Effective length: length=0 or length>BANK_DEPTH SHALL be treated as BANK_DEPTH; otherwise it is length.
REQ-019 Changes to bank_data after the snapshot edge SHALL NOT affect the burst.
REQ-020 In STREAM:
- out_valid=1
- out_data=shadow[index]
- select_line has only bit index set
- out_last=1 when index equals effective length-1
REQ-021 Handshake: an element transfers on an edge where out_valid and out_ready are both 1.
- With out_ready=0, out_data, select_line and out_last SHALL hold stable.
- out_valid SHALL NOT drop until the element transfers or the burst is aborted.
REQ-022 A transfer with out_last=0 SHALL increment index by 1.
REQ-023 A transfer with out_last=1 SHALL move the FSM to DONE.
REQ-024 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE; out_valid=0 in DONE.
REQ-025 start SHALL be ignored in STREAM and DONE; a start in the cycle after DONE begins a new burst.
REQ-026 abort=1 in STREAM or DONE SHALL force IDLE on the next edge, with no done pulse and no further transfer. abort overrides a transfer on the same edge.
REQ-027 abort in IDLE SHALL have no effect, and abort SHALL take priority over start.
REQ-028 Outside STREAM:
- out_valid=0
- out_last=0
- select_line=0
- out_data=0
REQ-029 Throughput: with out_ready held at 1, a burst of N elements SHALL take N consecutive STREAM cycles, and the first element SHALL appear on the cycle after start is sampled.
REQ-030 All outputs SHALL be functions of registered state only, with no combinational path from any input to any output.

Reset
REQ-031 reset=1 SHALL immediately, without waiting for a clock edge:
- force IDLE and clear index, the shadow bank and the latched length
- drive out_valid, out_last, busy and done to 0
- drive select_line and out_data to 0
REQ-032 reset asserted mid-burst SHALL abandon the burst with no done pulse. After release, the first start SHALL behave as in REQ-017.

Verification
REQ-033 Full burst: bank_data=0x0807060504030201, length=8, start pulse, out_ready=1.
- Response: out_data 01..08 on 8 consecutive cycles, select_line 0x01..0x80, out_last only with 0x08, then done pulse, then busy=0.
REQ-034 Backpressure: length=3, out_ready toggling 1,0,0,1,1.
- Response: elements 01,02,03 each transfer exactly once; outputs hold while out_ready=0.
REQ-035 Length clamp: length=0 and then length=12.
- Response: each burst streams 8 elements.
REQ-036 Snapshot: change bank_data to 0xFF.. one cycle after start.
- Response: the original values still stream.
REQ-037 Abort on element 3 with out_ready=1.
- Response: IDLE on the next edge, no done pulse, select_line=0.
- A subsequent start streams from element 0.
REQ-038 Async reset mid-burst, asserted between clock edges.
- Response: all outputs 0 immediately.
- After release, a start with length=2 yields 01,02 and then done.

Source files
------------

// File: rtl/bank_reader.sv
// Burst reader: snapshots a parallel bank and streams its elements one per
// accepted handshake, with length clamping, abort and a one-cycle done pulse.
module bank_reader #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           abort,
  input  logic [3:0]                     length,
  input  logic [DATA_WIDTH*BANK_DEPTH-1:0] bank_data,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic                           out_valid,
  output logic                           out_last,
  output logic [BANK_DEPTH-1:0]          select_line,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned IDX_W = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1;
  localparam int unsigned LEN_W = $clog2(BANK_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [IDX_W-1:0]      index_q;
  logic [LEN_W-1:0]      len_q;
  logic [DATA_WIDTH-1:0] shadow_q [BANK_DEPTH];
  logic [LEN_W-1:0]      eff_len_c;
  logic                  last_c;
  logic                  launch_c;
  logic                  advance_c;

  // Zero or oversize requests stream the whole bank.
  always_comb begin
    if (length == 4'd0 || 32'(length) > BANK_DEPTH) begin
      eff_len_c = LEN_W'(BANK_DEPTH);
    end else begin
      eff_len_c = LEN_W'(length);
    end
  end

  assign last_c    = (LEN_W'(index_q) == (len_q - LEN_W'(1)));
  assign launch_c  = (state_q == S_IDLE) && start && !abort;
  assign advance_c = (state_q == S_STREAM) && !abort && out_ready && !last_c;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort wins over both start and a transfer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (launch_c) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready && last_c) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Shadow bank, latched length and element index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index_q <= '0;
      len_q   <= '0;
      for (int i = 0; i < int'(BANK_DEPTH); i++) begin
        shadow_q[i] <= '0;
      end
    end else if (launch_c) begin
      index_q <= '0;
      len_q   <= eff_len_c;
      for (int i = 0; i < int'(BANK_DEPTH); i++) begin
        shadow_q[i] <= bank_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (advance_c) begin
      index_q <= index_q + IDX_W'(1);
    end
  end

  // Outputs decode registered state only.
  always_comb begin
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    select_line = '0;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    if (state_q == S_STREAM) begin
      out_valid   = 1'b1;
      out_last    = last_c;
      out_data    = shadow_q[index_q];
      select_line = BANK_DEPTH'(1) << index_q;
    end
  end

endmodule

// File: tb/tb_bank_reader.sv
// Directed self-checking bench for bank_reader; inputs change and outputs
// are sampled on the falling clock edge.
module tb_bank_reader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [3:0]  length;
  logic [63:0] bank_data;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [7:0]  select_line;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  localparam logic [63:0] BANK0 = 64'h0807060504030201;

  bank_reader #(.DATA_WIDTH(8), .BANK_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .length(length),
    .bank_data(bank_data), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .select_line(select_line),
    .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d,
                           input logic [7:0] s, input logic l, input logic b,
                           input logic dn);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_data"},  64'(out_data),  64'(d));
    chk({tag, "_sel"},   64'(select_line), 64'(s));
    chk({tag, "_last"},  64'(out_last),  64'(l));
    chk({tag, "_busy"},  64'(busy),      64'(b));
    chk({tag, "_done"},  64'(done),      64'(dn));
  endtask

  // Expected stream for element i (0-based) of BANK0 with effective length n.
  task automatic check_elem(input string tag, input int i, input int n);
    check_out(tag, 1'b1, 8'(i + 1), 8'(1) << i, (i == n - 1), 1'b1, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    check_out(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_done(input string tag);
    check_out(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1);
  endtask

  // Pulse start for one sampled edge; returns at the negedge of the first STREAM cycle.
  task automatic launch(input logic [3:0] len);
    length = len;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  logic       rdy_seq  [5];
  logic [7:0] data_seq [5];
  logic       last_seq [5];

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    length    = 4'd0;
    bank_data = BANK0;
    out_ready = 1'b1;
    #1;
    check_idle("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    // Full burst, length 8, no backpressure
    launch(4'd8);
    for (int i = 0; i < 8; i++) begin
      check_elem($sformatf("full_e%0d", i), i, 8);
      @(negedge clk);
    end
    check_done("full_done");
    @(negedge clk);
    check_idle("full_idle");

    // Backpressure with ready 1,0,0,1,1 over length 3
    rdy_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    data_seq = '{8'h01, 8'h02, 8'h02, 8'h02, 8'h03};
    last_seq = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    launch(4'd3);
    for (int c = 0; c < 5; c++) begin
      out_ready = rdy_seq[c];
      check_out($sformatf("bp_c%0d", c), 1'b1, data_seq[c],
                8'(1) << (data_seq[c] - 8'd1), last_seq[c], 1'b1, 1'b0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check_done("bp_done");
    @(negedge clk);
    check_idle("bp_idle");

    // Length clamp: 0 and 12 both stream 8 elements
    launch(4'd0);
    for (int i = 0; i < 8; i++) begin
      check_elem($sformatf("len0_e%0d", i), i, 8);
      @(negedge clk);
    end
    check_done("len0_done");
    @(negedge clk);
    launch(4'd12);
    for (int i = 0; i < 8; i++) begin
      check_elem($sformatf("len12_e%0d", i), i, 8);
      @(negedge clk);
    end
    check_done("len12_done");
    @(negedge clk);

    // Snapshot: bank changes after the start edge must not leak into the burst
    launch(4'd4);
    bank_data = '1;
    for (int i = 0; i < 4; i++) begin
      check_elem($sformatf("snap_e%0d", i), i, 4);
      @(negedge clk);
    end
    check_done("snap_done");
    @(negedge clk);
    bank_data = BANK0;

    // Abort on element 3, then restart from element 0
    launch(4'd8);
    check_elem("ab_e0", 0, 8);
    @(negedge clk);
    check_elem("ab_e1", 1, 8);
    @(negedge clk);
    check_elem("ab_e2", 2, 8);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("ab_idle");
    @(negedge clk);
    check_idle("ab_idle2");
    launch(4'd2);
    check_elem("ab_re0", 0, 2);
    @(negedge clk);
    check_elem("ab_re1", 1, 2);
    @(negedge clk);
    check_done("ab_redone");
    @(negedge clk);

    // Abort takes priority over start in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle("ab_vs_start");

    // Abort in DONE suppresses nothing visible but returns to IDLE
    launch(4'd1);
    check_elem("ad_e0", 0, 1);
    @(negedge clk);
    check_done("ad_done");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("ad_idle");

    // Async reset between edges mid-burst
    launch(4'd8);
    check_elem("rst_e0", 0, 8);
    @(negedge clk);
    check_elem("rst_e1", 1, 8);
    #2;
    reset = 1'b1;
    #1;
    check_idle("rst_async");
    @(negedge clk);
    reset = 1'b0;
    check_idle("rst_held");
    @(negedge clk);
    check_idle("rst_released");
    launch(4'd2);
    check_elem("rst_re0", 0, 2);
    @(negedge clk);
    check_elem("rst_re1", 1, 2);
    @(negedge clk);
    check_done("rst_redone");
    @(negedge clk);
    check_idle("rst_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
